read_burst: RTL

Read-path counterpart of the write burst serializer. It captures the 8-bit double-data-rate stream returned by the DDR3 memory on both clock edges and pairs consecutive beats into 16-bit words for the memory controller. A small state machine frames one read burst per `rd_start`, counts BL beats and flags the burst end. It sits between the DQ pad interface and the controller's read-data FIFO.

---
 rtl/read_burst_pkg.sv | 20 ++
 rtl/ddr_capture.sv | 42 ++++
 rtl/read_burst.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/read_burst_pkg.sv
// Shared types and defaults for the DDR read-burst deserializer.
// Optional error/abort logic in read_burst is enabled by defining READ_BURST_ERR_EN.
package read_burst_pkg;

  localparam int RB_BW      = 8;
  localparam int RB_BL      = 8;
  localparam int RB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURST = 2'd2
  } rb_state_t;

  // Word counter must hold the value WPB itself, hence the +1.
  function automatic int rb_cnt_w(input int wpb);
    return $clog2(wpb + 1);
  endfunction

endpackage

// File: rtl/ddr_capture.sv
// DDR beat capture: low beat and strobe latched on the falling edge, pair decode
// presented combinationally to the rising-edge logic in read_burst.
module ddr_capture
  import read_burst_pkg::*;
#(
  parameter int BW = RB_BW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [BW-1:0]   dq_in,
  input  logic            dqs_valid,
  output logic            pair_vld,
  output logic            pair_half,
  output logic [2*BW-1:0] pair_word
);

  logic [BW-1:0] lo_q, lo_d;
  logic          vld_q, vld_d;

  // Next values for the falling-edge capture registers.
  always_comb begin
    lo_d  = dq_in;
    vld_d = dqs_valid;
  end

  // Falling-edge capture of the low beat and its strobe; reset is honoured here too.
  always_ff @(negedge clock) begin
    if (reset) begin
      lo_q  <= {BW{1'b0}};
      vld_q <= 1'b0;
    end else begin
      lo_q  <= lo_d;
      vld_q <= vld_d;
    end
  end

  // A pair needs the strobe in both halves of the same cycle.
  assign pair_vld  = vld_q & dqs_valid;
  assign pair_half = vld_q & ~dqs_valid;
  assign pair_word = {dq_in, lo_q};

endmodule

// File: rtl/read_burst.sv
// Read-burst framer: pairs DDR beats into words and frames one burst per rd_start.
// Define READ_BURST_ERR_EN to add gap/half-pair/timeout error detection and abort.
module read_burst
  import read_burst_pkg::*;
#(
  parameter int BW      = RB_BW,
  parameter int BL      = RB_BL,
  parameter int TIMEOUT = RB_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rd_start,
  input  logic [BW-1:0]   dq_in,
  input  logic            dqs_valid,
  output logic [2*BW-1:0] data_out,
  output logic            valid_out,
  output logic            burst_done,
  output logic            busy,
  output logic            err
);

  localparam int WPB = BL / 2;
  localparam int CW  = rb_cnt_w(WPB);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WPB);

  logic            pair_vld_s;
  logic            pair_half_s;
  logic [2*BW-1:0] pair_word_s;

  rb_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*BW-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

`ifdef READ_BURST_ERR_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  logic unused_half_s;
  assign unused_half_s = pair_half_s;
`endif

  ddr_capture #(.BW(BW)) u_capture (
    .clock     (clock),
    .reset     (reset),
    .dq_in     (dq_in),
    .dqs_valid (dqs_valid),
    .pair_vld  (pair_vld_s),
    .pair_half (pair_half_s),
    .pair_word (pair_word_s)
  );

  // Burst framing: next state, word counter, output word and error tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef READ_BURST_ERR_EN
    err_d   = err_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        // Pairs arriving here are dropped; only rd_start matters.
        if (rd_start) begin
          state_d = ARMED;
          cnt_d   = CNT_ZERO;
`ifdef READ_BURST_ERR_EN
          err_d   = 1'b0;
          tmo_d   = TMO_ZERO;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (pair_vld_s) begin
          data_d  = pair_word_s;
          valid_d = 1'b1;
          cnt_d   = CNT_ONE;
          if (CNT_ONE == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end else begin
`ifdef READ_BURST_ERR_EN
          if (pair_half_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (tmo_q == TMO_LIM) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
`else
          state_d = ARMED;
`endif
        end
      end
      BURST: begin
        if (pair_vld_s) begin
          data_d  = pair_word_s;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if ((cnt_q + CNT_ONE) == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end else begin
`ifdef READ_BURST_ERR_EN
          // Any gap (including a half pair) aborts the burst.
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
`else
          state_d = BURST;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Rising-edge state and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      data_q  <= {(2*BW){1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef READ_BURST_ERR_EN
      err_q   <= 1'b0;
      tmo_q   <= TMO_ZERO;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef READ_BURST_ERR_EN
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign burst_done = done_q;
  assign busy       = (state_q != IDLE);
`ifdef READ_BURST_ERR_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule
